// File: rtl/ones_fill_pkg.sv
// ones_fill_pkg
//   Shared types and helpers for the ones_fill LED bar-graph block.
//   fill_state_t : IDLE / RUN / DONE controller states.
//   therm()      : thermometer code of a level, up to MAX_BITS wide.
//                  Used by the RTL to build the LED vector and by the bench
//                  checker to derive the expected LED pattern from a level.
package ones_fill_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;

  localparam int MAX_BITS = 64;
  localparam int LVL_W    = 7;

  // Level >= MAX_BITS is clamped to all ones so a full bar never needs
  // a shift by the full vector width.
  function automatic logic [MAX_BITS-1:0] therm(input logic [LVL_W-1:0] lvl);
    if (lvl >= 7'd64) return '1;
    return (MAX_BITS'(1) << lvl) - MAX_BITS'(1);
  endfunction

endpackage

// File: rtl/ones_fill_if.sv
// ones_fill_if
//   Valid/ready target handshake between a count source and ones_fill.
//   count_in    : requested number of lit LEDs (CNT_W bits)
//   count_valid : count_in is valid, driven by the source
//   count_ready : block can accept a new target, driven by ones_fill
//   master modport = count source, slave modport = ones_fill.
interface ones_fill_if #(
  parameter int BITS = 16
);
  localparam int CNT_W = $clog2(BITS) + 1;

  logic [CNT_W-1:0] count_in;
  logic             count_valid;
  logic             count_ready;

  modport master (output count_in, output count_valid, input count_ready);
  modport slave  (input count_in, input count_valid, output count_ready);

endinterface

// File: rtl/ones_fill_step_tick.sv
// step_tick
//   Step prescaler: emits a one-cycle tick every STEP_CYCLES enabled cycles.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clear_i : synchronous clear of the prescaler back to zero
//   en_i    : count enable
//   tick_o  : high during the cycle in which the prescaler is at its last count
module step_tick #(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  // A one-cycle period still needs a 1-bit counter that simply stays at 0.
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] presc_q, presc_d;

  assign tick_o = en_i && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = tick_o ? '0 : presc_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/ones_fill.sv
// ones_fill
//   Drives a BITS-wide bar graph whose lit length walks one LED per
//   STEP_CYCLES toward each accepted target count.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   cnt_if : slave side of the target handshake (count_in/valid/ready)
//   LED    : bar graph, LED[i] = 1 iff i < level
//   level  : current number of lit LEDs
//   busy   : high while moving toward a target and in the done cycle
//   done   : one-cycle pulse once level has reached the target
module ones_fill
  import ones_fill_pkg::*;
#(
  parameter  int BITS        = 16,
  parameter  int STEP_CYCLES = 1_000_000,
  localparam int CNT_W       = $clog2(BITS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ones_fill_if.slave       cnt_if,
  output logic [BITS-1:0]  LED,
  output logic [CNT_W-1:0] level,
  output logic             busy,
  output logic             done
);

  fill_state_t      state_q, state_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [BITS-1:0]  led_q;
  logic             ready_q, busy_q, done_q;
  logic             stepEn, stepTick;

  // The prescaler only runs while there is still distance to cover and is
  // held at zero outside RUN, so every fill starts a fresh step period.
  assign stepEn = (state_q == RUN) && (level_q != target_q);

  step_tick #(.STEP_CYCLES(STEP_CYCLES)) u_step_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(state_q != RUN),
    .en_i   (stepEn),
    .tick_o (stepTick)
  );

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_if.count_valid && ready_q) begin
          // Requests above the bar length saturate instead of wrapping.
          target_d = (cnt_if.count_in > CNT_W'(BITS)) ? CNT_W'(BITS) : cnt_if.count_in;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (level_q == target_q) begin
          state_d = DONE;
        end else if (stepTick) begin
          level_d = (target_q > level_q) ? level_q + CNT_W'(1) : level_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs are registered from next-state values so they line up with
  // the state they describe and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      led_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      led_q    <= BITS'(therm(LVL_W'(level_d)));
      ready_q  <= (state_d == IDLE);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign cnt_if.count_ready = ready_q;
  assign LED   = led_q;
  assign level = level_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
